// File: rtl/fb_write_arbiter_if.sv
// Requester-side write bus and frame-buffer write port of the frame buffer write arbiter.
// The master modport is the requester side; the slave modport is the arbiter itself.
interface fb_write_arbiter_if #(
  parameter int unsigned N_REQ           = 2,
  parameter int unsigned PIXEL_NUM_WIDTH = 17
);
  logic [N_REQ-1:0]                 req;
  logic [N_REQ-1:0]                 last;
  logic [N_REQ-1:0]                 wr_en;
  logic [N_REQ*PIXEL_NUM_WIDTH-1:0] wr_addr;
  logic [N_REQ-1:0]                 wr_data;
  logic [N_REQ-1:0]                 gnt;
  logic                             ram_write_en;
  logic [PIXEL_NUM_WIDTH-1:0]       ram_write_addr;
  logic                             ram_data;

  modport master (
    output req, last, wr_en, wr_addr, wr_data,
    input  gnt, ram_write_en, ram_write_addr, ram_data
  );

  modport slave (
    input  req, last, wr_en, wr_addr, wr_data,
    output gnt, ram_write_en, ram_write_addr, ram_data
  );
endinterface

// File: rtl/fb_write_arbiter.sv
// Round-robin, burst-locked arbiter for the single 1-bit LCD frame buffer write port.
// Grants are registered; the owner's writes pass through combinationally.
module fb_write_arbiter #(
  parameter int unsigned N_REQ           = 2,
  parameter int unsigned PIXEL_NUM_WIDTH = 17,
  parameter int unsigned HOLD_TIMEOUT    = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  fb_write_arbiter_if.slave bus,
  output logic              busy,
  output logic              collision,
  output logic              timeout
);

  localparam int unsigned PtrW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CntW = (HOLD_TIMEOUT > 0) ? $clog2(HOLD_TIMEOUT + 1) : 1;

  typedef enum logic [0:0] {StArb, StGrant} state_e;

  state_e                     state_q, state_d;
  logic [N_REQ-1:0]           gnt_q, gnt_d;
  logic [PtrW-1:0]            ptr_q, ptr_d;
  logic [PtrW-1:0]            owner_q, owner_d;
  logic [CntW-1:0]            idle_q, idle_d;
  logic                       collision_q, collision_d;
  logic [PtrW-1:0]            winner;
  logic                       found;
  logic                       own_req, own_wr, own_last, expire;
  logic [PIXEL_NUM_WIDTH-1:0] addr_arr [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_addr
    assign addr_arr[i] = bus.wr_addr[i*PIXEL_NUM_WIDTH +: PIXEL_NUM_WIDTH];
  end

  assign own_req  = bus.req[owner_q];
  assign own_wr   = bus.wr_en[owner_q];
  assign own_last = bus.last[owner_q];
  assign expire   = (HOLD_TIMEOUT != 0) && (idle_q == CntW'(HOLD_TIMEOUT - 1));

  // Cyclic search starting at ptr; the index wraps at N_REQ, not at a power of two.
  always_comb begin
    int unsigned      idx;
    logic [PtrW-1:0]  idx_w;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    idx_w  = '0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      idx   = (32'(ptr_q) + off) % N_REQ;
      idx_w = PtrW'(idx);
      if (!found && bus.req[idx_w]) begin
        found  = 1'b1;
        winner = idx_w;
      end
    end
  end

  always_comb begin
    state_d            = state_q;
    gnt_d              = gnt_q;
    ptr_d              = ptr_q;
    owner_d            = owner_q;
    idle_d             = idle_q;
    collision_d        = collision_q | (|(bus.wr_en & ~gnt_q));
    timeout            = 1'b0;
    bus.ram_write_en   = 1'b0;
    bus.ram_write_addr = '0;
    bus.ram_data       = 1'b0;

    if (state_q == StGrant) begin
      bus.ram_write_en   = own_wr & en;
      bus.ram_write_addr = addr_arr[owner_q];
      bus.ram_data       = bus.wr_data[owner_q];
    end

    if (en) begin
      unique case (state_q)
        StArb: begin
          if (found) begin
            state_d = StGrant;
            gnt_d   = N_REQ'(1) << winner;
            owner_d = winner;
            idle_d  = '0;
          end
        end
        StGrant: begin
          timeout = expire;
          if (!own_req || (own_wr && own_last) || expire) begin
            state_d = StArb;
            gnt_d   = '0;
            ptr_d   = (owner_q == PtrW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
          end else if (own_wr) begin
            idle_d = '0;
          end else if (HOLD_TIMEOUT != 0) begin
            idle_d = idle_q + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StArb;
      gnt_q       <= '0;
      ptr_q       <= '0;
      owner_q     <= '0;
      idle_q      <= '0;
      collision_q <= 1'b0;
    end else if (en) begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      idle_q      <= idle_d;
      collision_q <= collision_d;
    end
  end

  assign bus.gnt   = gnt_q;
  assign busy      = |gnt_q;
  assign collision = collision_q;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Self-checking bench for fb_write_arbiter: directed scenarios plus a randomized run
// compared against a cycle-level behavioural model of the arbitration rules.
module tb_fb_write_arbiter;
  localparam int N  = 2;
  localparam int W  = 17;
  localparam int HT = 8;
  localparam int AW = N * W;

  logic clk = 1'b0;
  logic reset;
  logic en;
  logic busy, collision, timeout;

  fb_write_arbiter_if #(.N_REQ(N), .PIXEL_NUM_WIDTH(W)) bus ();

  fb_write_arbiter #(.N_REQ(N), .PIXEL_NUM_WIDTH(W), .HOLD_TIMEOUT(HT)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .bus       (bus),
    .busy      (busy),
    .collision (collision),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model: owner -1 means nobody holds the port.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_idle  = 0;
  bit m_coll  = 1'b0;

  task automatic cyc();
    bit wr;
    bit got;
    int cand;
    @(posedge clk);
    if (reset) begin
      m_owner = -1; m_ptr = 0; m_idle = 0; m_coll = 1'b0;
    end else if (en) begin
      for (int i = 0; i < N; i++) if (bus.wr_en[i] && i != m_owner) m_coll = 1'b1;
      if (m_owner < 0) begin
        got = 1'b0;
        for (int off = 0; off < N; off++) begin
          cand = (m_ptr + off) % N;
          if (!got && bus.req[cand]) begin
            got = 1'b1; m_owner = cand; m_idle = 0;
          end
        end
      end else begin
        wr = bus.wr_en[m_owner];
        if (!bus.req[m_owner] || (wr && bus.last[m_owner]) || m_idle == HT - 1) begin
          m_ptr = (m_owner + 1) % N;
          m_owner = -1;
        end else begin
          m_idle = wr ? 0 : m_idle + 1;
        end
      end
    end
    #1;
  endtask

  task automatic clear_inputs();
    bus.req = '0; bus.last = '0; bus.wr_en = '0; bus.wr_addr = '0; bus.wr_data = '0;
    en = 1'b1;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [N+W+5-1:0] got;
    do_reset();
    #1;
    got = {bus.gnt, bus.ram_write_en, bus.ram_write_addr, bus.ram_data, busy, collision, timeout};
    n_checks++;
    if (got !== '0) $display("FAIL reset_outputs: got %h, want 0", got);
    else n_pass++;
  endtask

  task automatic test_single_burst();
    int errs = 0;
    int seen = 0;
    logic dat;
    do_reset();
    bus.req = 2'b01;
    cyc();
    n_checks++;
    if (bus.gnt !== 2'b01) $display("FAIL burst_grant: gnt %b, want 01", bus.gnt);
    else n_pass++;
    for (int a = 0; a < 76800; a++) begin
      dat = a[0] ^ a[5] ^ a[11];
      bus.wr_en   = 2'b01;
      bus.wr_addr = '0;
      bus.wr_addr[W-1:0] = W'(a);
      bus.wr_data = {1'b0, dat};
      bus.last    = (a == 76799) ? 2'b01 : 2'b00;
      #1;
      if (bus.ram_write_en === 1'b1) seen++;
      if (bus.ram_write_en !== 1'b1 || bus.ram_write_addr !== W'(a) || bus.ram_data !== dat)
        errs++;
      cyc();
    end
    n_checks++;
    if (seen !== 76800) $display("FAIL burst_write_count: got %0d, want 76800", seen);
    else n_pass++;
    n_checks++;
    if (errs !== 0) $display("FAIL burst_write_match: %0d bad writes, want 0", errs);
    else n_pass++;
    clear_inputs();
    #1;
    n_checks++;
    if (bus.gnt !== 2'b00) $display("FAIL burst_release: gnt %b, want 00", bus.gnt);
    else n_pass++;
    cyc();
    bus.req = 2'b11;
    cyc();
    n_checks++;
    if (bus.gnt !== 2'b10) $display("FAIL burst_ptr_next: gnt %b, want 10", bus.gnt);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_seq [16] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b10,
                                   2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b10};
    int cnt = 0;
    int k;
    do_reset();
    bus.req = 2'b11;
    for (int c = 0; c < 16; c++) begin
      if (bus.gnt == 2'b00) begin
        bus.wr_en = '0; bus.last = '0; cnt = 0;
      end else begin
        k = bus.gnt[1] ? 1 : 0;
        bus.wr_en = N'(1) << k;
        bus.last  = (cnt == 2) ? (N'(1) << k) : '0;
        cnt++;
      end
      #1;
      n_checks++;
      if (bus.gnt !== exp_seq[c])
        $display("FAIL rr_order[%0d]: gnt %b, want %b", c, bus.gnt, exp_seq[c]);
      else n_pass++;
      cyc();
    end
  endtask

  task automatic test_collision();
    do_reset();
    bus.req = 2'b01;
    cyc();
    for (int i = 0; i < 4; i++) begin
      bus.wr_en   = 2'b11;
      bus.last    = 2'b10;
      bus.wr_addr = {W'(100), W'(10 + i)};
      bus.wr_data = 2'b10;
      #1;
      n_checks++;
      if (bus.ram_write_en !== 1'b1 || bus.ram_write_addr !== W'(10 + i) || bus.ram_data !== 1'b0)
        $display("FAIL coll_owner_write[%0d]: en %b addr %0d data %b, want 1 %0d 0", i,
                 bus.ram_write_en, bus.ram_write_addr, bus.ram_data, 10 + i);
      else n_pass++;
      cyc();
    end
    bus.wr_en = 2'b01; bus.last = 2'b01;
    cyc();
    clear_inputs();
    cyc();
    cyc();
    n_checks++;
    if (collision !== 1'b1) $display("FAIL coll_sticky: collision %b, want 1", collision);
    else n_pass++;
    do_reset();
    #1;
    n_checks++;
    if (collision !== 1'b0) $display("FAIL coll_reset: collision %b, want 0", collision);
    else n_pass++;
  endtask

  task automatic test_watchdog();
    do_reset();
    bus.req = 2'b10;
    cyc();
    bus.req = 2'b11;
    for (int c = 1; c <= 8; c++) begin
      #1;
      n_checks++;
      if (timeout !== (c == 8))
        $display("FAIL wd_timeout[%0d]: timeout %b, want %b", c, timeout, c == 8);
      else n_pass++;
      cyc();
    end
    n_checks++;
    if (bus.gnt !== 2'b00) $display("FAIL wd_release: gnt %b, want 00", bus.gnt);
    else n_pass++;
    cyc();
    n_checks++;
    if (bus.gnt !== 2'b01) $display("FAIL wd_next_owner: gnt %b, want 01", bus.gnt);
    else n_pass++;
  endtask

  task automatic test_en_gating();
    do_reset();
    bus.req = 2'b01;
    cyc();
    bus.wr_en = 2'b01;
    for (int i = 0; i < 10; i++) begin
      en = !(i >= 2 && i < 7);
      bus.wr_addr = AW'(i + 200);
      #1;
      n_checks++;
      if (bus.ram_write_en !== en || bus.gnt !== 2'b01)
        $display("FAIL en_gate[%0d]: we %b gnt %b, want %b 01", i, bus.ram_write_en, bus.gnt, en);
      else n_pass++;
      cyc();
    end
    clear_inputs();
    cyc();
  endtask

  task automatic test_reset_mid_burst();
    logic [N+W+5-1:0] got;
    do_reset();
    bus.req = 2'b01;
    cyc();
    for (int i = 1; i <= 50; i++) begin
      bus.wr_en = 2'b01;
      bus.wr_addr = AW'(i);
      bus.wr_data = 2'b01;
      reset = (i == 50);
      cyc();
    end
    reset = 1'b0;
    bus.wr_en = '0;
    #1;
    got = {bus.gnt, bus.ram_write_en, bus.ram_write_addr, bus.ram_data, busy, collision, timeout};
    n_checks++;
    if (got !== '0) $display("FAIL midreset_outputs: got %h, want 0", got);
    else n_pass++;
    bus.req = 2'b11;
    cyc();
    n_checks++;
    if (bus.gnt !== 2'b01) $display("FAIL midreset_ptr: gnt %b, want 01", bus.gnt);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [N+W+5-1:0] got, exp;
    logic [N-1:0]     eg;
    logic             ewe, ed, et;
    logic [W-1:0]     ea;
    int               wr_pct;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      wr_pct = ((c / 500) % 2 == 0) ? 70 : 15;
      if ($urandom_range(0, 3) == 0) bus.req = N'($urandom());
      bus.wr_en   = {N{1'b0}};
      for (int i = 0; i < N; i++) bus.wr_en[i] = ($urandom_range(0, 99) < wr_pct);
      bus.last    = ($urandom_range(0, 5) == 0) ? N'($urandom()) : '0;
      bus.wr_addr = AW'({$urandom(), $urandom()});
      bus.wr_data = N'($urandom());
      en          = ($urandom_range(0, 15) != 0);
      reset       = ($urandom_range(0, 499) == 0);
      #1;
      eg  = (m_owner < 0) ? '0 : (N'(1) << m_owner);
      ewe = (m_owner >= 0) && en && bus.wr_en[m_owner[0]];
      ea  = (m_owner >= 0) ? bus.wr_addr[m_owner*W +: W] : '0;
      ed  = (m_owner >= 0) ? bus.wr_data[m_owner[0]] : 1'b0;
      et  = (m_owner >= 0) && en && (m_idle == HT - 1);
      exp = {eg, ewe, ea, ed, m_owner >= 0, m_coll, et};
      got = {bus.gnt, bus.ram_write_en, bus.ram_write_addr, bus.ram_data, busy, collision, timeout};
      n_checks++;
      if (got !== exp) $display("FAIL random[%0d]: got %h, want %h", c, got, exp);
      else n_pass++;
      cyc();
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_single_burst();
    test_round_robin();
    test_collision();
    test_watchdog();
    test_en_gating();
    test_reset_mid_burst();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fb_write_arbiter.md
Name: fb_write_arbiter

Overview:
- Shares the single 1-bit LCD frame buffer write port between N_REQ requesters, e.g. the painter (index 0) and a result/overlay writer (index 1).
- Uses registered, round-robin, burst-locked grants. A requester keeps the port until it signals the last write or drops its request.
- Only the granted requester's write reaches the frame buffer. An idle watchdog stops a stalled requester from holding the port.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- PIXEL_NUM_WIDTH, 17, frame buffer address width.
- HOLD_TIMEOUT, 1024, number of consecutive granted cycles with no write after which the grant is force-released; 0 disables the watchdog.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous active-high reset.
- en  input  1  clock enable; when low, FSM, pointer and counters freeze and ram_write_en is forced to 0.
- req  input  N_REQ  per-requester port request; stays high while the requester wants the port.
- last  input  N_REQ  qualifies a write as the final write of the burst.
- wr_en  input  N_REQ  per-requester write strobe.
- wr_addr  input  N_REQ*PIXEL_NUM_WIDTH  packed addresses; requester i uses slice [i*W +: W].
- wr_data  input  N_REQ  per-requester pixel data.
- gnt  output  N_REQ  registered one-hot grant.
- ram_write_en  output  1  frame buffer write enable.
- ram_write_addr  output  PIXEL_NUM_WIDTH  frame buffer write address.
- ram_data  output  1  frame buffer pixel data.
- busy  output  1  high while any grant is active.
- collision  output  1  sticky flag: a non-granted requester asserted wr_en.
- timeout  output  1  one-cycle pulse on a watchdog release.

Behaviour:
- Clock and reset: all state updates on posedge clk. Reset has priority over en.
- Reset values: gnt=0, ptr=0, state=ARB, busy=0, collision=0, timeout=0, idle counter=0.
- ram_write_en/addr/data are combinational from the granted requester; when nothing is granted they are 0, 0, 0.
- States:
  - ARB:
    - If any req bit is high, pick the first requester at or after ptr, searching cyclically modulo N_REQ.
    - Set gnt[winner] on the next clock and go to GRANT.
    - If no req is high, stay in ARB.
    - Arbitration latency is 1 cycle from req to gnt.
  - GRANT (owner k):
    - ram_write_en = wr_en[k] & en; addr and data come from slice k, in the same cycle (zero write latency).
    - Release when req[k]=0, or when wr_en[k]&last[k], or on watchdog expiry.
    - On release: gnt clears on the next clock, ptr <= (k+1) mod N_REQ, state goes to ARB.
    - The write in the release cycle (wr_en&last) is still performed.
    - Guaranteed turnaround: gnt is all-zero for at least 1 cycle between owners, so there is no direct handoff.
- Watchdog:
  - The idle counter clears on every granted write and on grant start, and increments on each granted cycle without a write.
  - When it reaches HOLD_TIMEOUT-1, the grant releases exactly as above and timeout pulses high for that release cycle.
- Dropped writes:
  - wr_en from any i≠k (or any i in ARB) is dropped and sets collision=1 until reset.
  - last without wr_en has no effect.
- Simultaneous events:
  - Multiple req in ARB: round-robin from ptr.
  - Owner releasing while others request: others are arbitrated in the following ARB cycle.
  - req[k] dropping in the same cycle as wr_en[k]: the write is performed, then release.
- en low: no state/pointer/counter change, outputs gated (ram_write_en=0, gnt held). Writes attempted during en low are lost; collision is not updated.
- Reset mid-burst: grant removed next cycle, ptr=0, no write occurs in the reset cycle's successor.
- Width rules:
  - ptr width is $clog2(N_REQ) (minimum 1).
  - Idle counter width is $clog2(HOLD_TIMEOUT+1).
  - The ptr increment wraps explicitly at N_REQ, not at the power of 2.

Test Plan:
- Single burst:
  - Stimulus: reset, then req[0]=1 at cycle 0; wr_en[0]=1 for addresses 0..76799, with last on 76799.
  - Required: gnt=2'b01 at cycle 1; 76800 writes reach ram_write_* with matching addr/data; gnt=0 the cycle after the last write; ptr=1.
- Round-robin:
  - Stimulus: req=2'b11 held, each owner does 3 writes with last on the 3rd.
  - Required: grant order 0,1,0,1 with one all-zero gnt cycle between owners.
- Collision:
  - Stimulus: while req 0 is granted, wr_en[1]=1 with addr 100.
  - Required: no write to addr 100; collision=1 and stays 1 until reset; owner 0 writes unaffected.
- Watchdog:
  - Stimulus: HOLD_TIMEOUT=8; requester 1 is granted and holds req with no writes.
  - Required: timeout pulses on the 8th granted cycle; gnt clears next cycle; pending req[0] is granted 2 cycles later.
- en gating:
  - Stimulus: during a burst, en=0 for 5 cycles while wr_en[0]=1.
  - Required: ram_write_en=0 throughout; gnt unchanged; burst resumes when en=1.
- Reset mid-burst:
  - Stimulus: assert reset at write 50 of a burst.
  - Required: all outputs 0 next cycle; next arbitration starts from ptr=0.
